// File: rtl/min_scan.sv
// Sequential minimum-reduction engine: folds a candidate stream through an external min-select comparator.
// Optional winner-index output enabled by defining MIN_SCAN_IDX_EN.
module min_scan #(
    parameter int N_CNT_W = 8
) (
    input  logic               m_clock,
    input  logic               p_reset,
    input  logic               abort,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [7:0]         in_ene,
    input  logic [7:0]         in_dir,
    input  logic               in_last,
    output logic [7:0]         sel_ene1,
    output logic [7:0]         sel_ene2,
    output logic [7:0]         sel_dir1,
    output logic [7:0]         sel_dir2,
    output logic               sel_exe,
    input  logic [7:0]         sel_outene,
    input  logic [7:0]         sel_outplot,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_ene,
    output logic [7:0]         res_dir,
    output logic [N_CNT_W-1:0] res_cnt
`ifdef MIN_SCAN_IDX_EN
    ,
    output logic [N_CNT_W-1:0] res_idx
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N_CNT_W-1:0] CNT_MAX = {N_CNT_W{1'b1}};

    state_t             state_reg, state_next;
    logic [7:0]         acc_ene_reg, acc_ene_next;
    logic [7:0]         acc_dir_reg, acc_dir_next;
    logic [N_CNT_W-1:0] cnt_reg, cnt_next;
    logic               accept;
`ifdef MIN_SCAN_IDX_EN
    logic [N_CNT_W-1:0] idx_reg, idx_next;
`endif

    always_ff @(posedge m_clock or negedge p_reset) begin
        if (!p_reset) begin
            state_reg   <= IDLE;
            acc_ene_reg <= 8'hFF;
            acc_dir_reg <= 8'h00;
            cnt_reg     <= '0;
`ifdef MIN_SCAN_IDX_EN
            idx_reg     <= '0;
`endif
        end else begin
            state_reg   <= state_next;
            acc_ene_reg <= acc_ene_next;
            acc_dir_reg <= acc_dir_next;
            cnt_reg     <= cnt_next;
`ifdef MIN_SCAN_IDX_EN
            idx_reg     <= idx_next;
`endif
        end
    end

    assign in_ready = (state_reg != DONE);
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_next   = state_reg;
        acc_ene_next = acc_ene_reg;
        acc_dir_next = acc_dir_reg;
        cnt_next     = cnt_reg;
`ifdef MIN_SCAN_IDX_EN
        idx_next     = idx_reg;
`endif
        sel_ene1     = 8'h00;
        sel_ene2     = 8'h00;
        sel_dir1     = 8'h00;
        sel_dir2     = 8'h00;
        sel_exe      = 1'b0;

        case (state_reg)
            IDLE: begin
                // First candidate seeds the accumulator without a comparison.
                if (accept) begin
                    acc_ene_next = in_ene;
                    acc_dir_next = in_dir;
                    cnt_next     = {{(N_CNT_W-1){1'b0}}, 1'b1};
`ifdef MIN_SCAN_IDX_EN
                    idx_next     = '0;
`endif
                    state_next   = in_last ? DONE : ACC;
                end
            end
            ACC: begin
                sel_exe = in_valid;
                if (in_valid) begin
                    sel_ene1 = in_ene;
                    sel_dir1 = in_dir;
                    sel_ene2 = acc_ene_reg;
                    sel_dir2 = acc_dir_reg;
                end
                if (accept) begin
                    acc_ene_next = sel_outene;
                    acc_dir_next = sel_outplot;
                    if (cnt_reg != CNT_MAX)
                        cnt_next = cnt_reg + 1'b1;
`ifdef MIN_SCAN_IDX_EN
                    // Comparator keeps the accumulator on ties, so a changed energy means a new winner.
                    if (sel_outene != acc_ene_reg)
                        idx_next = cnt_reg;
`endif
                    if (in_last)
                        state_next = DONE;
                end
            end
            DONE: begin
                if (res_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (abort) begin
            state_next   = IDLE;
            acc_ene_next = 8'hFF;
            acc_dir_next = 8'h00;
            cnt_next     = '0;
`ifdef MIN_SCAN_IDX_EN
            idx_next     = '0;
`endif
        end
    end

    assign res_valid = (state_reg == DONE);
    assign res_ene   = acc_ene_reg;
    assign res_dir   = acc_dir_reg;
    assign res_cnt   = cnt_reg;
`ifdef MIN_SCAN_IDX_EN
    assign res_idx   = idx_reg;
`endif

endmodule

// File: tb/tb_min_scan.sv
// Directed self-checking bench for min_scan; models the min-select comparator (port 1 wins only if strictly less).
module tb_min_scan;

    logic       m_clock = 1'b0;
    logic       p_reset = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_ene = 8'h00;
    logic [7:0] in_dir = 8'h00;
    logic       in_last = 1'b0;
    logic [7:0] sel_ene1, sel_ene2, sel_dir1, sel_dir2;
    logic       sel_exe;
    logic [7:0] sel_outene, sel_outplot;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_ene, res_dir;
    logic [7:0] res_cnt;
`ifdef MIN_SCAN_IDX_EN
    logic [7:0] res_idx;
`endif

    int checks = 0;
    int failures = 0;

    always #5 m_clock = ~m_clock;

    assign sel_outene  = (sel_ene1 < sel_ene2) ? sel_ene1 : sel_ene2;
    assign sel_outplot = (sel_ene1 < sel_ene2) ? sel_dir1 : sel_dir2;

    min_scan #(.N_CNT_W(8)) dut (
        .m_clock(m_clock), .p_reset(p_reset), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_ene(in_ene), .in_dir(in_dir), .in_last(in_last),
        .sel_ene1(sel_ene1), .sel_ene2(sel_ene2), .sel_dir1(sel_dir1), .sel_dir2(sel_dir2),
        .sel_exe(sel_exe), .sel_outene(sel_outene), .sel_outplot(sel_outplot),
        .res_valid(res_valid), .res_ready(res_ready), .res_ene(res_ene), .res_dir(res_dir),
        .res_cnt(res_cnt)
`ifdef MIN_SCAN_IDX_EN
        , .res_idx(res_idx)
`endif
    );

    task automatic cand(input logic [7:0] e, input logic [7:0] d, input logic l);
        in_valid = 1'b1; in_ene = e; in_dir = d; in_last = l;
        @(posedge m_clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        @(posedge m_clock); #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0h exp=0", res_valid); end
        checks++; if (res_ene !== 8'hFF) begin failures++; $display("FAIL rst_ene got=%0h exp=ff", res_ene); end
        checks++; if (res_dir !== 8'h00 || res_cnt !== 8'h00) begin failures++; $display("FAIL rst_dir_cnt got=%0h/%0h exp=0/0", res_dir, res_cnt); end
        checks++; if (in_ready !== 1'b1 || sel_exe !== 1'b0 || sel_ene1 !== 8'h00) begin failures++; $display("FAIL rst_rdy_sel got=%0b/%0b/%0h exp=1/0/0", in_ready, sel_exe, sel_ene1); end
        @(negedge m_clock); p_reset = 1'b1;
        @(posedge m_clock); #1;
        $display("reset: released");
    endtask

    task automatic test_stream();
        cand(8'd5, 8'd1, 1'b0);
        in_valid = 1'b1; in_ene = 8'd3; in_dir = 8'd2; #1;
        checks++; if (sel_exe !== 1'b1 || sel_ene1 !== 8'd3 || sel_ene2 !== 8'd5 || sel_dir2 !== 8'd1)
            begin failures++; $display("FAIL acc_drive got=%0b/%0d/%0d/%0d exp=1/3/5/1", sel_exe, sel_ene1, sel_ene2, sel_dir2); end
        @(posedge m_clock); #1;
        cand(8'd9, 8'd3, 1'b0);
        in_valid = 1'b1; in_ene = 8'd3; in_dir = 8'd4; in_last = 1'b1; #1;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL early_valid got=%0b exp=0", res_valid); end
        @(posedge m_clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL stream_valid got=%0b exp=1", res_valid); end
        checks++; if (res_ene !== 8'd3 || res_dir !== 8'd2) begin failures++; $display("FAIL stream_min got=%0d/%0d exp=3/2", res_ene, res_dir); end
        checks++; if (res_cnt !== 8'd4) begin failures++; $display("FAIL stream_cnt got=%0d exp=4", res_cnt); end
`ifdef MIN_SCAN_IDX_EN
        checks++; if (res_idx !== 8'd1) begin failures++; $display("FAIL stream_idx got=%0d exp=1", res_idx); end
`endif
        handshake();
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL stream_release got=%0b/%0b exp=0/1", res_valid, in_ready); end
        $display("stream: 5,3,9,3 -> ene=%0d dir=%0d cnt=%0d", res_ene, res_dir, res_cnt);
    endtask

    task automatic test_single();
        in_valid = 1'b1; in_ene = 8'h42; in_dir = 8'd7; in_last = 1'b1; #1;
        checks++; if (sel_exe !== 1'b0 || sel_ene1 !== 8'h00) begin failures++; $display("FAIL single_sel got=%0b/%0h exp=0/0", sel_exe, sel_ene1); end
        @(posedge m_clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_ene !== 8'h42 || res_dir !== 8'd7 || res_cnt !== 8'd1)
            begin failures++; $display("FAIL single_res got=%0b/%0h/%0d/%0d exp=1/42/7/1", res_valid, res_ene, res_dir, res_cnt); end
`ifdef MIN_SCAN_IDX_EN
        checks++; if (res_idx !== 8'd0) begin failures++; $display("FAIL single_idx got=%0d exp=0", res_idx); end
`endif
        $display("single: 0x42/7 -> ene=%0h cnt=%0d", res_ene, res_cnt);
    endtask

    task automatic test_hold();
        in_valid = 1'b1; in_ene = 8'h11; in_dir = 8'd5; in_last = 1'b1; res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (in_ready !== 1'b0 || sel_exe !== 1'b0 || res_valid !== 1'b1 || res_ene !== 8'h42)
                begin failures++; $display("FAIL hold_%0d got=%0b/%0b/%0b/%0h exp=0/0/1/42", i, in_ready, sel_exe, res_valid, res_ene); end
            @(posedge m_clock);
        end
        #1;
        res_ready = 1'b1;
        @(posedge m_clock); #1;
        res_ready = 1'b0;
        checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL hold_release got=%0b/%0b exp=0/1", res_valid, in_ready); end
        @(posedge m_clock); #1;
        in_valid = 1'b0; in_last = 1'b0;
        checks++; if (res_valid !== 1'b1 || res_ene !== 8'h11 || res_dir !== 8'd5 || res_cnt !== 8'd1)
            begin failures++; $display("FAIL hold_next got=%0b/%0h/%0d/%0d exp=1/11/5/1", res_valid, res_ene, res_dir, res_cnt); end
        handshake();
        $display("hold: result stable 3 cycles, next scan ene=11");
    endtask

    task automatic test_abort();
        cand(8'd5, 8'd1, 1'b0);
        cand(8'd6, 8'd2, 1'b0);
        abort = 1'b1; in_valid = 1'b1; in_ene = 8'h00; in_dir = 8'd9;
        @(posedge m_clock); #1;
        abort = 1'b0; in_valid = 1'b0;
        checks++; if (in_ready !== 1'b1 || res_ene !== 8'hFF || res_cnt !== 8'd0 || res_valid !== 1'b0)
            begin failures++; $display("FAIL abort_clear got=%0b/%0h/%0d/%0b exp=1/ff/0/0", in_ready, res_ene, res_cnt, res_valid); end
        cand(8'h10, 8'd3, 1'b1);
        checks++; if (res_valid !== 1'b1 || res_ene !== 8'h10 || res_cnt !== 8'd1)
            begin failures++; $display("FAIL abort_rescan got=%0b/%0h/%0d exp=1/10/1", res_valid, res_ene, res_cnt); end
        handshake();
        $display("abort: rescan ene=%0h cnt=%0d", res_ene, res_cnt);
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) cand(8'hFF, 8'd1, 1'b0);
        cand(8'h00, 8'd9, 1'b1);
        checks++; if (res_cnt !== 8'd255) begin failures++; $display("FAIL sat_cnt got=%0d exp=255", res_cnt); end
        checks++; if (res_ene !== 8'h00 || res_dir !== 8'd9) begin failures++; $display("FAIL sat_min got=%0h/%0d exp=0/9", res_ene, res_dir); end
`ifdef MIN_SCAN_IDX_EN
        checks++; if (res_idx !== 8'd255) begin failures++; $display("FAIL sat_idx got=%0d exp=255", res_idx); end
`endif
        $display("saturate: 301 candidates -> cnt=%0d ene=%0h", res_cnt, res_ene);
    endtask

    task automatic test_async_reset();
        @(posedge m_clock); #3;
        p_reset = 1'b0; #1;
        checks++; if (res_valid !== 1'b0 || res_ene !== 8'hFF || res_dir !== 8'h00 || res_cnt !== 8'd0)
            begin failures++; $display("FAIL areset_res got=%0b/%0h/%0d/%0d exp=0/ff/0/0", res_valid, res_ene, res_dir, res_cnt); end
        checks++; if (in_ready !== 1'b1 || sel_exe !== 1'b0) begin failures++; $display("FAIL areset_rdy got=%0b/%0b exp=1/0", in_ready, sel_exe); end
        @(negedge m_clock); p_reset = 1'b1;
        $display("async_reset: outputs at reset values");
    endtask

    initial begin
        test_reset();
        test_stream();
        test_single();
        test_hold();
        test_abort();
        test_saturate();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/min_scan.md
# min_scan

Sequential minimum-reduction engine that drives the two-input min-select comparator as its initiator. It accepts a stream of (energy, direction) candidates from the bidirectional-search expansion stage and folds them one per cycle through the comparator. It returns the global minimum energy, its direction code and the candidate count on a valid/ready result port. It sits between the neighbour-expansion logic and the frontier update of each search direction.

## Interface
- `N_CNT_W`, default 8: width of the candidate counter; the count saturates at 2^N_CNT_W−1.
- `m_clock`  in  1  clock; all state updates on its rising edge.
- `p_reset`  in  1  asynchronous reset, active-low. Asserting it clears all state immediately.
- `abort`  in  1  synchronous discard of any scan in progress.
- `in_valid`  in  1  candidate present.
- `in_ready`  out  1  candidate accepted when `in_valid & in_ready`.
- `in_ene`  in  8  candidate energy, unsigned.
- `in_dir`  in  8  candidate ud/lr direction code.
- `in_last`  in  1  final candidate of this scan.
- `sel_ene1`, `sel_ene2`  out  8  comparator energy inputs.
- `sel_dir1`, `sel_dir2`  out  8  comparator direction inputs.
- `sel_exe`  out  1  comparator enable.
- `sel_outene`  in  8  comparator selected energy.
- `sel_outplot`  in  8  comparator selected direction.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  result consumed when `res_valid & res_ready`.
- `res_ene`  out  8  minimum energy.
- `res_dir`  out  8  direction of the minimum.
- `res_cnt`  out  N_CNT_W  number of candidates in the scan, saturating.
- `res_idx`  out  N_CNT_W  position of the winning candidate in the scan; present only when MIN_SCAN_IDX_EN is defined.

## Operation
- States: IDLE (no accumulator), ACC (accumulator holds the running minimum), DONE (result held).
- `in_ready` = 1 in IDLE and ACC, 0 in DONE.
- IDLE, on accept:
  - Load acc_ene/acc_dir directly from the candidate; the comparator is not used.
  - cnt ← 1, idx ← 0.
  - Go to ACC, or to DONE if `in_last`.
- ACC, combinational comparator drive:
  - `sel_ene1=in_ene`, `sel_dir1=in_dir`, `sel_ene2=acc_ene`, `sel_dir2=acc_dir`.
  - `sel_exe = in_valid`.
- ACC, on accept:
  - acc ← (`sel_outene`, `sel_outplot`).
  - cnt ← cnt+1, saturating.
  - Go to DONE if `in_last`.
- Tie rule: the comparator picks port 1 only when strictly less, so on equal energy the earlier candidate (the accumulator) wins.
- When `sel_exe` = 0, all `sel_*` outputs are driven 0.
- DONE:
  - `res_valid` = 1; `res_*` = accumulator and count.
  - Result stays stable until the handshake completes, then the block returns to IDLE.
- `abort`, any state: go to IDLE, clear the accumulator, `res_valid` ← 0. `abort` has priority over a same-cycle accept or result handshake.
- A scan always holds at least one candidate; an empty scan does not exist.

## Timing
- Reset values:
  - `res_valid`=0, `res_ene`=8'hFF, `res_dir`=0, `res_cnt`=0, `res_idx`=0.
  - `sel_*`=0; state IDLE, so `in_ready`=1.
- Throughput: one candidate per cycle, with no bubble between candidates.
- Latency: `res_valid` rises on the edge that accepts the `in_last` candidate, i.e. it is visible the next cycle.
- Back-to-back scans: the result handshake edge returns the block to IDLE, and the next candidate is accepted one cycle later. There is one dead cycle per scan.
- A result handshake and `in_valid` in the same DONE cycle: the candidate is not accepted (`in_ready`=0).
- Reset asserted mid-scan: the partial result is lost and `res_valid` drops asynchronously.

## Configuration
- `MIN_SCAN_IDX_EN` defined:
  - Adds the `res_idx` port and an index register.
  - On each ACC accept where the candidate wins (`sel_outene != acc_ene`), idx ← current candidate position (cnt before increment).
  - The index saturates with the count.
- Undefined: neither the port nor the register exists, and all other behaviour is identical.

## Test plan
- Reset, then stream 5, 3, 9, 3(last) with dirs 1, 2, 3, 4 → `res_ene`=3, `res_dir`=2, `res_cnt`=4, `res_idx`=1, with `res_valid` one cycle after the last accept.
- Single candidate 0x42/dir 7 with `in_last` → result 0x42/7, cnt 1, idx 0, and `sel_exe` never asserted.
- Hold `res_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and the result stays stable. After the handshake, IDLE accepts the next candidate one cycle later.
- `abort` asserted mid-scan after two candidates, then a new scan of 0x10 → result 0x10, cnt 1.
- 300 candidates all 0xFF, then one 0x00 last → cnt saturates at 255, `res_ene`=0.
- Assert `p_reset` low asynchronously while in DONE → `res_valid` drops immediately and all outputs take their reset values.
